// File: rtl/gm_filter_pkg.sv
// Shared widths, coefficients and rounding/saturation constants for the
// gm_filter_model 8-tap low-pass FIR.
package gm_filter_pkg;

    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int TAPS = 8;
    localparam int AW   = 19;

    // Q1.7 taps, h0 multiplies the newest sample; they sum to 128 (unity DC gain).
    localparam logic signed [CW-1:0] COEF [TAPS] = '{
        -8'sd2, 8'sd6, 8'sd22, 8'sd38, 8'sd38, 8'sd22, 8'sd6, -8'sd2
    };

    localparam logic signed [AW-1:0] RND_K   = 19'sd64;
    localparam int                   SHIFT   = 7;
    localparam logic signed [DW-1:0] SAT_MAX = 8'sh7F;
    localparam logic signed [DW-1:0] SAT_MIN = 8'sh80;

endpackage

// File: rtl/gm_filter_round_sat.sv
// Combinational round-half-up and saturate from the full-precision
// accumulator back to the sample width.
module gm_filter_round_sat
    import gm_filter_pkg::*;
(
    input  logic signed [AW-1:0] acc,
    output logic signed [DW-1:0] res
);

    function automatic logic signed [AW-1:0] round_half_up(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] biased;
        biased = v + RND_K;
        return biased >>> SHIFT;
    endfunction

    function automatic logic signed [DW-1:0] saturate(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] hi;
        logic signed [AW-1:0] lo;
        hi = AW'(SAT_MAX);
        lo = AW'(SAT_MIN);
        if (v > hi)
            return SAT_MAX;
        else if (v < lo)
            return SAT_MIN;
        else
            return v[DW-1:0];
    endfunction

    assign res = saturate(round_half_up(acc));

endmodule

// File: rtl/gm_filter_model.sv
// 8-tap direct-form FIR low-pass reference model: delay line, MAC and a
// single output register, all advancing only on clk_enable.
module gm_filter_model
    import gm_filter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_enable,
    input  logic signed [DW-1:0] x,
    output logic                 ce_out,
    output logic signed [DW-1:0] y
);

    // d7 would only ever be discarded, so the line holds d0..d6.
    logic signed [DW-1:0]    dly [TAPS-1];
    logic signed [DW-1:0]    tap [TAPS];
    logic signed [DW+CW-1:0] prod [TAPS];
    logic signed [AW-1:0]    acc;
    logic signed [DW-1:0]    y_next;

    assign ce_out = clk_enable;

    always_comb begin
        tap[0] = x;
        for (int k = 1; k < TAPS; k++)
            tap[k] = dly[k-1];
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            prod[k] = tap[k] * COEF[k];
            acc     = acc + AW'(prod[k]);
        end
    end

    gm_filter_round_sat u_round_sat (
        .acc (acc),
        .res (y_next)
    );

    // Output stage: shift the line and register the rounded result together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS-1; k++)
                dly[k] <= '0;
            y <= '0;
        end else if (clk_enable) begin
            dly[0] <= x;
            for (int k = 1; k < TAPS-1; k++)
                dly[k] <= dly[k-1];
            y <= y_next;
        end
    end

endmodule

// File: tb/tb_gm_filter_model.sv
// Directed-vector bench for gm_filter_model: reset, impulse, DC gain,
// saturation, clock enable and mid-stream reset.
module tb_gm_filter_model;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_enable;
    logic signed [7:0] x;
    logic              ce_out;
    logic signed [7:0] y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gm_filter_model dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .x          (x),
        .ce_out     (ce_out),
        .y          (y)
    );

    task automatic cycle(input logic [7:0] xv, input logic en);
        x          = xv;
        clk_enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        x          = 8'h00;
        clk_enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle((i % 2) ? 8'hAA : 8'h55, 1'b1);
            checks++;
            if (y !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d] got %h want 00", i, y);
            end
            checks++;
            if (ce_out !== 1'b1) begin
                errors++;
                $display("FAIL reset_ce_out[%0d] got %b want 1", i, ce_out);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1'b1);
            checks++;
            if (y !== 8'h00) begin
                errors++;
                $display("FAIL reset_release[%0d] got %h want 00", i, y);
            end
        end
    endtask

    task automatic test_impulse();
        logic [7:0] exp_y [10] = '{8'hFE, 8'h06, 8'h16, 8'h26, 8'h26,
                                   8'h16, 8'h06, 8'hFE, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle((i == 0) ? 8'h7F : 8'h00, 1'b1);
            checks++;
            if (y !== exp_y[i]) begin
                errors++;
                $display("FAIL impulse[%0d] got %h want %h", i, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_dc_gain();
        logic [7:0] exp_pos [10] = '{8'hFE, 8'h04, 8'h1A, 8'h40, 8'h65,
                                     8'h7B, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        logic [7:0] exp_neg [10] = '{8'h02, 8'hFC, 8'hE6, 8'hC0, 8'h9A,
                                     8'h84, 8'h80, 8'h80, 8'h80, 8'h80};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(8'h7F, 1'b1);
            checks++;
            if (y !== exp_pos[i]) begin
                errors++;
                $display("FAIL dc_pos[%0d] got %h want %h", i, y, exp_pos[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(8'h80, 1'b1);
            checks++;
            if (y !== exp_neg[i]) begin
                errors++;
                $display("FAIL dc_neg[%0d] got %h want %h", i, y, exp_neg[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] seq [8] = '{8'h80, 8'h7F, 8'h7F, 8'h7F,
                                8'h7F, 8'h7F, 8'h7F, 8'h80};
        do_reset();
        for (int i = 0; i < 8; i++)
            cycle(seq[i], 1'b1);
        checks++;
        if (y !== 8'h7F) begin
            errors++;
            $display("FAIL saturation got %h want 7f", y);
        end
    endtask

    task automatic test_clock_enable();
        logic [7:0] exp_tail [7] = '{8'h16, 8'h26, 8'h26, 8'h16, 8'h06, 8'hFE, 8'h00};
        do_reset();
        cycle(8'h7F, 1'b1);
        checks++;
        if (y !== 8'hFE) begin
            errors++;
            $display("FAIL ce_first got %h want fe", y);
        end
        cycle(8'h00, 1'b1);
        checks++;
        if (y !== 8'h06) begin
            errors++;
            $display("FAIL ce_second got %h want 06", y);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(8'h55, 1'b0);
            checks++;
            if (y !== 8'h06) begin
                errors++;
                $display("FAIL ce_hold[%0d] got %h want 06", i, y);
            end
            checks++;
            if (ce_out !== 1'b0) begin
                errors++;
                $display("FAIL ce_out_low[%0d] got %b want 0", i, ce_out);
            end
        end
        for (int i = 0; i < 7; i++) begin
            cycle(8'h00, 1'b1);
            checks++;
            if (y !== exp_tail[i]) begin
                errors++;
                $display("FAIL ce_resume[%0d] got %h want %h", i, y, exp_tail[i]);
            end
        end
        checks++;
        if (ce_out !== 1'b1) begin
            errors++;
            $display("FAIL ce_out_high got %b want 1", ce_out);
        end
    endtask

    task automatic test_midstream_reset();
        logic [7:0] exp_pos [10] = '{8'hFE, 8'h04, 8'h1A, 8'h40, 8'h65,
                                     8'h7B, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(8'h7F, 1'b1);
        checks++;
        if (y !== 8'h65) begin
            errors++;
            $display("FAIL mid_pre got %h want 65", y);
        end
        rst = 1'b0;
        #2;
        checks++;
        if (y !== 8'h00) begin
            errors++;
            $display("FAIL mid_async got %h want 00", y);
        end
        cycle(8'h7F, 1'b1);
        checks++;
        if (y !== 8'h00) begin
            errors++;
            $display("FAIL mid_held got %h want 00", y);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(8'h7F, 1'b1);
            checks++;
            if (y !== exp_pos[i]) begin
                errors++;
                $display("FAIL mid_ramp[%0d] got %h want %h", i, y, exp_pos[i]);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        clk_enable = 1'b0;
        x          = 8'h00;
        #1;
        checks++;
        if (y !== 8'h00) begin
            errors++;
            $display("FAIL reset_initial got %h want 00", y);
        end
        test_reset();
        test_impulse();
        test_dc_gain();
        test_saturation();
        test_clock_enable();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
